// File: rtl/tag_symbol_scheduler.sv
// Serialises payload bytes into 2-bit phase symbols (LSB dibit first) for the tag phase
// modulator, starting a fixed preamble holdoff after each excitation-packet start pulse.
module tag_symbol_scheduler #(
   parameter int SYMBOL_CYCLES = 20,
   parameter int DELAY_CYCLES  = 3840,
   parameter int LEN_WIDTH     = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] frame_len,
   input  logic [7:0]           byte_data,
   input  logic                 byte_valid,
   output logic                 byte_ready,
   output logic                 trigger_signal,
   output logic [1:0]           state_input,
   output logic                 busy,
   output logic                 done,
   output logic                 underrun
);
   localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam int SW = $clog2(SYMBOL_CYCLES);
   localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);
   localparam logic [SW-1:0] SYM_LAST   = SW'(SYMBOL_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RUN, ST_DONE} state_t;

   state_t               state_q, state_d;
   logic [DW-1:0]        delay_cnt_q, delay_cnt_d;
   logic [SW-1:0]        sym_cnt_q, sym_cnt_d;
   logic [1:0]           dib_cnt_q, dib_cnt_d;
   logic [LEN_WIDTH-1:0] bytes_left_q, bytes_left_d;
   logic [7:0]           shift_q, shift_d;
   logic [7:0]           hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 trigger_q, trigger_d;
   logic [1:0]           sym_q, sym_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 underrun_q, underrun_d;
   logic                 load_byte;
   logic [7:0]           next_byte;

   // An empty holding register at a byte boundary still consumes the slot, as zeros.
   assign next_byte = hold_full_q ? hold_q : 8'h00;

   always_comb begin
      state_d      = state_q;
      delay_cnt_d  = delay_cnt_q;
      sym_cnt_d    = sym_cnt_q;
      dib_cnt_d    = dib_cnt_q;
      bytes_left_d = bytes_left_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      trigger_d    = trigger_q;
      sym_d        = sym_q;
      busy_d       = busy_q;
      done_d       = done_q;
      underrun_d   = underrun_q;
      load_byte    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               underrun_d = 1'b0;
               if (frame_len != '0) begin
                  state_d      = ST_DELAY;
                  delay_cnt_d  = '0;
                  bytes_left_d = frame_len;
                  busy_d       = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_DELAY: begin
            if (delay_cnt_q == DELAY_LAST) begin
               state_d   = ST_RUN;
               load_byte = 1'b1;
            end else begin
               delay_cnt_d = delay_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (sym_cnt_q == SYM_LAST) begin
               sym_cnt_d = '0;
               if (dib_cnt_q == 2'd3) begin
                  if (bytes_left_q == LEN_WIDTH'(1)) begin
                     state_d   = ST_DONE;
                     trigger_d = 1'b0;
                     sym_d     = 2'b00;
                     busy_d    = 1'b0;
                     done_d    = 1'b1;
                  end else begin
                     bytes_left_d = bytes_left_q - 1'b1;
                     load_byte    = 1'b1;
                  end
               end else begin
                  dib_cnt_d = dib_cnt_q + 1'b1;
                  sym_d     = shift_q[3:2];
                  shift_d   = {2'b00, shift_q[7:2]};
               end
            end else begin
               sym_cnt_d = sym_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
         end
      endcase

      if (load_byte) begin
         shift_d   = next_byte;
         sym_d     = next_byte[1:0];
         trigger_d = 1'b1;
         sym_cnt_d = '0;
         dib_cnt_d = 2'd0;
         if (hold_full_q) hold_full_d = 1'b0;
         else             underrun_d  = 1'b1;
      end

      // Accept only when empty, so this never collides with a drain on the same edge.
      if (byte_valid && !hold_full_q) begin
         hold_d      = byte_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         delay_cnt_q  <= '0;
         sym_cnt_q    <= '0;
         dib_cnt_q    <= 2'd0;
         bytes_left_q <= '0;
         shift_q      <= 8'h00;
         hold_q       <= 8'h00;
         hold_full_q  <= 1'b0;
         trigger_q    <= 1'b0;
         sym_q        <= 2'b00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         delay_cnt_q  <= delay_cnt_d;
         sym_cnt_q    <= sym_cnt_d;
         dib_cnt_q    <= dib_cnt_d;
         bytes_left_q <= bytes_left_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         trigger_q    <= trigger_d;
         sym_q        <= sym_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign byte_ready     = !hold_full_q;
   assign trigger_signal = trigger_q;
   assign state_input    = sym_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign underrun       = underrun_q;

endmodule

// File: tb/tb_tag_symbol_scheduler.sv
// Bench for tag_symbol_scheduler: drives frames with random bytes and feed gaps and compares
// every cycle against a slot-level model of the symbol stream and holding register.
module tb_tag_symbol_scheduler;
   localparam int S  = 4;
   localparam int D  = 8;
   localparam int LW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] frame_len = '0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_valid = 1'b0;
   logic          byte_ready, trigger_signal, busy, done, underrun;
   logic [1:0]    state_input;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model: bytes handed over (with the edge they transferred on), sticky underrun flag.
   logic [7:0] avail_data[$];
   int         avail_edge[$];
   logic       m_underrun = 1'b0;
   logic [7:0] feed_q[$];
   int         feed_pct = 100;

   int         first_trig_s, done_s, trig_cnt;
   logic [1:0] obs_sym[$];

   tag_symbol_scheduler #(
      .SYMBOL_CYCLES(S),
      .DELAY_CYCLES (D),
      .LEN_WIDTH    (LW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .frame_len     (frame_len),
      .byte_data     (byte_data),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .trigger_signal(trigger_signal),
      .state_input   (state_input),
      .busy          (busy),
      .done          (done),
      .underrun      (underrun)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Offer the next queued byte; a transfer happens at the coming edge when ready is high.
   task automatic feed_drive();
      if (feed_q.size() > 0 && $urandom_range(99) < feed_pct) begin
         byte_valid = 1'b1;
         byte_data  = feed_q[0];
         if (byte_ready) begin
            avail_data.push_back(feed_q.pop_front());
            avail_edge.push_back(cyc + 1);
         end
      end else begin
         byte_valid = 1'b0;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         n_checks += 4;
         if (trigger_signal !== 1'b0 || state_input !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs cyc=%0d trig=%b sym=%0d busy=%b done=%b required 0 0 0 0",
                     cyc, trigger_signal, state_input, busy, done);
         end
         if (underrun !== m_underrun) begin
            n_fail++;
            $display("FAIL idle_underrun cyc=%0d got %b required %b", cyc, underrun, m_underrun);
         end
         if (byte_ready !== (avail_data.size() == 0)) begin
            n_fail++;
            $display("FAIL idle_ready cyc=%0d got %b required %b", cyc, byte_ready, avail_data.size() == 0);
         end
         feed_drive();
      end
   endtask

   // s counts cycles from the one in which start is high (s=0).
   task automatic run_frame(input int len, input bit noisy, input int abort_s);
      int run_lo, run_hi, total, k;
      logic [7:0] cur;
      logic exp_trig, exp_busy, exp_done, exp_ready;
      logic [1:0] exp_sym;
      cur = 8'h00;
      first_trig_s = -1; done_s = -1; trig_cnt = 0; obs_sym.delete();
      run_lo = (len == 0) ? 1 : D + 1;
      run_hi = run_lo + 4 * S * len;
      total  = run_hi + 2;
      @(negedge clock);
      start = 1'b1; frame_len = LW'(len);
      feed_drive();
      for (int s = 1; s <= total; s++) begin
         @(negedge clock);
         start = 1'b0;
         if (s == 1) m_underrun = 1'b0;
         if (s >= run_lo && s < run_hi && (s - run_lo) % (4 * S) == 0) begin
            if (avail_data.size() > 0 && avail_edge[0] < cyc) begin
               cur = avail_data.pop_front();
               void'(avail_edge.pop_front());
            end else begin
               cur = 8'h00;
               m_underrun = 1'b1;
            end
         end
         exp_trig  = (s >= run_lo && s < run_hi);
         k         = exp_trig ? ((s - run_lo) / S) % 4 : 0;
         exp_sym   = exp_trig ? cur[2*k +: 2] : 2'b00;
         exp_busy  = (s < run_hi);
         exp_done  = (s == run_hi);
         exp_ready = (avail_data.size() == 0);
         if (trigger_signal === 1'b1) begin
            trig_cnt++;
            if (first_trig_s < 0) first_trig_s = s;
         end
         if (done === 1'b1 && done_s < 0) done_s = s;
         if (exp_trig && (s - run_lo) % S == 0) obs_sym.push_back(state_input);
         n_checks += 6;
         if (trigger_signal !== exp_trig) begin
            n_fail++; $display("FAIL trigger s=%0d got %b required %b", s, trigger_signal, exp_trig);
         end
         if (state_input !== exp_sym) begin
            n_fail++; $display("FAIL state_input s=%0d got %0d required %0d", s, state_input, exp_sym);
         end
         if (busy !== exp_busy) begin
            n_fail++; $display("FAIL busy s=%0d got %b required %b", s, busy, exp_busy);
         end
         if (done !== exp_done) begin
            n_fail++; $display("FAIL done s=%0d got %b required %b", s, done, exp_done);
         end
         if (underrun !== m_underrun) begin
            n_fail++; $display("FAIL underrun s=%0d got %b required %b", s, underrun, m_underrun);
         end
         if (byte_ready !== exp_ready) begin
            n_fail++; $display("FAIL byte_ready s=%0d got %b required %b", s, byte_ready, exp_ready);
         end
         if (s == abort_s) begin
            byte_valid = 1'b0;
            $display("frame len=%0d aborted at s=%0d", len, s);
            return;
         end
         if (noisy && s < run_hi && $urandom_range(3) == 0) begin
            start = 1'b1;
            frame_len = LW'($urandom);
         end
         if (s < total) feed_drive();
         else           byte_valid = 1'b0;
      end
      feed_q.delete();
      $display("frame len=%0d first_trigger_s=%0d done_s=%0d trigger_cycles=%0d underrun=%b",
               len, first_trig_s, done_s, trig_cnt, underrun);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      n_checks++;
      if (trigger_signal !== 1'b0 || state_input !== 2'b00 || busy !== 1'b0 || done !== 1'b0
          || underrun !== 1'b0 || byte_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state got trig=%b sym=%0d busy=%b done=%b underrun=%b ready=%b required 0 0 0 0 0 1",
                  trigger_signal, state_input, busy, done, underrun, byte_ready);
      end
      reset = 1'b1;
      idle_cycles(20);
   endtask

   task automatic test_single_byte();
      logic [1:0] exp_tbl[$] = '{2'd0, 2'd1, 2'd3, 2'd2};
      feed_q.push_back(8'hB4);
      idle_cycles(3);
      run_frame(1, 1'b0, 0);
      n_checks += 3;
      if (first_trig_s != D + 1) begin
         n_fail++; $display("FAIL single_first_trigger got %0d required %0d", first_trig_s, D + 1);
      end
      if (done_s != D + 1 + 4 * S) begin
         n_fail++; $display("FAIL single_done got %0d required %0d", done_s, D + 1 + 4 * S);
      end
      if (obs_sym.size() != 4 || obs_sym != exp_tbl) begin
         n_fail++; $display("FAIL single_symbols got %p required %p", obs_sym, exp_tbl);
      end
   endtask

   task automatic test_multi_byte();
      logic [1:0] exp_tbl[$] = '{3, 2, 1, 0, 0, 1, 2, 3, 3, 3, 3, 3};
      feed_q = '{8'h1B, 8'hE4, 8'hFF};
      run_frame(3, 1'b0, 0);
      n_checks += 3;
      if (obs_sym != exp_tbl) begin
         n_fail++; $display("FAIL multi_symbols got %p required %p", obs_sym, exp_tbl);
      end
      if (trig_cnt != 48) begin
         n_fail++; $display("FAIL multi_trigger_cycles got %0d required 48", trig_cnt);
      end
      if (underrun !== 1'b0) begin
         n_fail++; $display("FAIL multi_underrun got %b required 0", underrun);
      end
   endtask

   task automatic test_underrun();
      logic [1:0] exp_tbl[$] = '{1, 1, 1, 1, 0, 0, 0, 0};
      feed_q = '{8'h55};
      run_frame(2, 1'b0, 0);
      idle_cycles(5);
      n_checks += 2;
      if (obs_sym != exp_tbl) begin
         n_fail++; $display("FAIL underrun_symbols got %p required %p", obs_sym, exp_tbl);
      end
      if (underrun !== 1'b1) begin
         n_fail++; $display("FAIL underrun_sticky got %b required 1", underrun);
      end
   endtask

   task automatic test_zero_len_and_ignored_starts();
      run_frame(0, 1'b0, 0);
      n_checks += 2;
      if (done_s != 1) begin
         n_fail++; $display("FAIL zero_len_done got %0d required 1", done_s);
      end
      if (trig_cnt != 0) begin
         n_fail++; $display("FAIL zero_len_trigger got %0d required 0", trig_cnt);
      end
      idle_cycles(2);
      feed_q = '{8'($urandom), 8'($urandom)};
      run_frame(2, 1'b1, 0);
      n_checks += 2;
      if (first_trig_s != D + 1) begin
         n_fail++; $display("FAIL ignored_start_trigger got %0d required %0d", first_trig_s, D + 1);
      end
      if (done_s != D + 1 + 8 * S) begin
         n_fail++; $display("FAIL ignored_start_done got %0d required %0d", done_s, D + 1 + 8 * S);
      end
      idle_cycles(2);
   endtask

   task automatic test_random_frames();
      int len, nb;
      for (int f = 0; f < 8; f++) begin
         len = $urandom_range(1, 4);
         nb  = $urandom_range(len - 1, len + 1);
         for (int b = 0; b < nb; b++) feed_q.push_back(8'($urandom));
         feed_pct = $urandom_range(5, 100);
         run_frame(len, 1'($urandom_range(1)), 0);
         feed_pct = 100;
         idle_cycles($urandom_range(1, 4));
      end
   endtask

   task automatic test_reset_mid_run();
      feed_q = '{8'h3C, 8'hA7};
      run_frame(2, 1'b0, D + 1 + 6);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (trigger_signal !== 1'b0 || state_input !== 2'b00 || busy !== 1'b0 || byte_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_abort got trig=%b sym=%0d busy=%b ready=%b required 0 0 0 1",
                  trigger_signal, state_input, busy, byte_ready);
      end
      avail_data.delete(); avail_edge.delete(); feed_q.delete();
      m_underrun = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      test_single_byte();
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_multi_byte();
      test_underrun();
      test_zero_len_and_ignored_starts();
      test_random_frames();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
